// File: rtl/clk_ctrl_pkg.sv
// Shared encodings and defaults for the clock-ratio controller and its period counter.
package clk_ctrl_pkg;

  localparam int unsigned DefaultCntW  = 6;
  localparam int unsigned DefaultRatio = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StPend = 2'd2
  } state_e;

endpackage

// File: rtl/clk_ratio_counter.sv
// Half-period counter: terminal detect plus registered clock_slower / slow_tick generation.
module clk_ratio_counter
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_ratio,
  output logic             o_clk_slow,
  output logic             o_slow_tick,
  output logic             o_term,
  output logic             o_fall
);

  logic [CNT_W-1:0] r_count;
  logic             r_clk_slow;
  logic             r_slow_tick;
  logic             w_term;

  // ratio is never 0, so ratio-1 never underflows and count stays in range
  assign w_term = i_run && (r_count == (i_ratio - CNT_W'(1)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count     <= '0;
      r_clk_slow  <= 1'b0;
      r_slow_tick <= 1'b0;
    end else begin
      r_slow_tick <= w_term;
      if (w_term) begin
        r_count    <= '0;
        r_clk_slow <= ~r_clk_slow;
      end else if (i_run) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_clk_slow  = r_clk_slow;
  assign o_slow_tick = r_slow_tick;
  assign o_term      = w_term;
  assign o_fall      = w_term && r_clk_slow;

endmodule

// File: rtl/clk_ratio_ctrl.sv
// Clock-ratio controller: 2x toggle, divided slow toggle, boundary-safe ratio updates.
// Optional full-period counter output enabled by CLK_RATIO_CTRL_PERIOD_CNT_EN.
module clk_ratio_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W         = DefaultCntW,
  parameter int unsigned DEFAULT_RATIO = DefaultRatio,
  parameter int unsigned MIN_RATIO     = 1
) (
  input  logic             original_clock,
  input  logic             reset_in,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_ratio,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clock_2x,
  output logic             clock_slower,
  output logic             slow_tick,
  output logic [CNT_W-1:0] ratio_cur,
  output logic             busy
`ifdef CLK_RATIO_CTRL_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_ratio_cur;
  logic [CNT_W-1:0] r_pending;
  logic             r_cfg_ready;
  logic             r_cfg_err;
  logic             r_clk2x;
  logic             r_busy;

  logic [CNT_W-1:0] w_ratio_next;
  logic [CNT_W-1:0] w_pending_next;
  logic             w_clk2x_next;
  logic             w_run;
  logic             w_term;
  logic             w_fall;
  logic             w_accept;
  logic             w_legal;
  logic             w_take;

  assign w_run    = (r_state != StIdle);
  assign w_accept = cfg_valid && r_cfg_ready;
  assign w_legal  = (cfg_ratio >= CNT_W'(MIN_RATIO));
  assign w_take   = w_accept && w_legal;

  clk_ratio_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .i_clk       (original_clock),
    .i_rst       (reset_in),
    .i_run       (w_run),
    .i_ratio     (r_ratio_cur),
    .o_clk_slow  (clock_slower),
    .o_slow_tick (slow_tick),
    .o_term      (w_term),
    .o_fall      (w_fall)
  );

  // State register
  always_ff @(posedge original_clock) begin
    if (reset_in) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; stop and ratio swap only happen on a full-period (falling) boundary
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (enable) w_state_next = StRun;
      StRun: begin
        if (w_fall && !enable) begin
          w_state_next = StIdle;
        end else if (w_take) begin
          w_state_next = StPend;
        end
      end
      StPend: if (w_fall) w_state_next = enable ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_ratio_next   = r_ratio_cur;
    w_pending_next = r_pending;
    unique case (r_state)
      StIdle: if (w_take) w_ratio_next = cfg_ratio;
      StRun: begin
        if (w_take) begin
          // Stopping this edge: nothing left to defer to, so the request takes effect at restart
          if (w_state_next == StIdle) begin
            w_ratio_next = cfg_ratio;
          end else begin
            w_pending_next = cfg_ratio;
          end
        end
      end
      StPend: if (w_fall) w_ratio_next = r_pending;
      default: ;
    endcase

    if (r_state == StIdle) begin
      w_clk2x_next = r_clk2x;
    end else if (w_state_next == StIdle) begin
      w_clk2x_next = 1'b1;
    end else begin
      w_clk2x_next = ~r_clk2x;
    end
  end

  always_ff @(posedge original_clock) begin
    if (reset_in) begin
      r_ratio_cur <= CNT_W'(DEFAULT_RATIO);
      r_pending   <= '0;
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
      r_clk2x     <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_ratio_cur <= w_ratio_next;
      r_pending   <= w_pending_next;
      r_cfg_ready <= (w_state_next != StPend);
      r_cfg_err   <= w_accept && !w_legal;
      r_clk2x     <= w_clk2x_next;
      r_busy      <= (w_state_next != StIdle);
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign cfg_err   = r_cfg_err;
  assign clock_2x  = r_clk2x;
  assign ratio_cur = r_ratio_cur;
  assign busy      = r_busy;

`ifdef CLK_RATIO_CTRL_PERIOD_CNT_EN
  logic [15:0] r_period_cnt;

  always_ff @(posedge original_clock) begin
    if (reset_in) begin
      r_period_cnt <= '0;
    end else if (w_fall && (r_period_cnt != 16'hFFFF)) begin
      r_period_cnt <= r_period_cnt + 16'd1;
    end
  end

  assign period_cnt = r_period_cnt;
`endif

endmodule
